// File: rtl/sdram_pkg.sv
// sdram_pkg: shared widths, FSM states and address helper
// for the SDRAM burst bridge.
package sdram_pkg;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 24;
  localparam int BURST_W = 10;
  localparam int USED_W  = 25;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_DATA,
    RD_REQ,
    RD_DATA
  } state_e;

  // Advance a burst pointer, folding back to base at region end.
  function automatic logic [ADDR_W-1:0] wrap_add(
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] inc,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] size
  );
    logic [ADDR_W:0] nxt;
    logic [ADDR_W:0] lim;
    nxt = {1'b0, addr} + {1'b0, inc};
    lim = {1'b0, base} + {1'b0, size};
    if (nxt == lim) begin
      return base;
    end
    return nxt[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead FIFO with a registered head word,
// registered full/empty flags and an occupancy level.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_L = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // Next pointers, count and head word; bypass when the
  // slot being written becomes the new head.
  always_comb begin
    wptr_d = wptr_q + AW'(do_push);
    rptr_d = rptr_q + AW'(do_pop);
    cnt_d  = cnt_q + (AW+1)'(do_push)
                   - (AW+1)'(do_pop);
    dout_d = dout_q;
    if (cnt_d != '0) begin
      if (do_push && (wptr_q == rptr_d)) begin
        dout_d = data_i;
      end else begin
        dout_d = mem_q[rptr_d];
      end
    end
  end

  // Storage array, written on accepted pushes.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointer, count, head and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      full_q  <= (cnt_d == FULL_L);
      empty_q <= (cnt_d == '0);
    end
  end

  assign data_o  = dout_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = cnt_q;

endmodule

// File: rtl/sdram_burst_bridge.sv
// sdram_burst_bridge: user stream FIFOs in front of sdram_controller.
// Write bursts fill a circular region; read bursts refill the read side.
module sdram_burst_bridge
  import sdram_pkg::*;
#(
  parameter int                BURST        = 256,
  parameter int                FIFO_DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 24'h000000,
  parameter logic [ADDR_W-1:0] REGION_WORDS = 24'h010000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               wr_full,
  input  logic               rd_en,
  output logic [DATA_W-1:0]  rd_data,
  output logic               rd_empty,
  output logic               overflow,
  output logic [USED_W-1:0]  region_used,
  input  logic               sdram_init_done,
  output logic               sdram_wr_req,
  input  logic               sdram_wr_ack,
  output logic [ADDR_W-1:0]  sdram_wr_addr,
  output logic [BURST_W-1:0] sdram_wr_burst,
  output logic [DATA_W-1:0]  sdram_din,
  output logic               sdram_rd_req,
  input  logic               sdram_rd_ack,
  output logic [ADDR_W-1:0]  sdram_rd_addr,
  output logic [BURST_W-1:0] sdram_rd_burst,
  input  logic [DATA_W-1:0]  sdram_dout
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0] BURST_L = LW'(BURST);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [USED_W-1:0] BURST_U = USED_W'(BURST);
  localparam logic [USED_W-1:0] ROOM_U =
    USED_W'(REGION_WORDS) - BURST_U;
  localparam logic [ADDR_W-1:0] BURST_A = ADDR_W'(BURST);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [USED_W-1:0] used_q, used_d;
  logic              ovf_q, ovf_d;
  logic              wr_pop, rd_push;
  logic              wr_go, rd_go;
  logic [LW-1:0]     wr_lvl, rd_lvl;
  logic              wr_empty_unused;
  logic              rd_full_unused;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (wr_en),
    .data_i  (wr_data),
    .pop_i   (wr_pop),
    .data_o  (sdram_din),
    .full_o  (wr_full),
    .empty_o (wr_empty_unused),
    .level_o (wr_lvl)
  );

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (rd_push),
    .data_i  (sdram_dout),
    .pop_i   (rd_en),
    .data_o  (rd_data),
    .full_o  (rd_full_unused),
    .empty_o (rd_empty),
    .level_o (rd_lvl)
  );

  assign wr_go = (wr_lvl >= BURST_L)
              && (used_q <= ROOM_U);
  assign rd_go = (used_q >= BURST_U)
              && ((DEPTH_L - rd_lvl) >= BURST_L);

  // Burst sequencer: write wins arbitration, pointers and
  // region fill move one burst on each ack fall.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    used_d       = used_q;
    wr_pop       = 1'b0;
    rd_push      = 1'b0;
    sdram_wr_req = 1'b0;
    sdram_rd_req = 1'b0;
    ovf_d        = ovf_q | (wr_en & wr_full);
    unique case (state_q)
      IDLE: begin
        if (sdram_init_done) begin
          if (wr_go) begin
            state_d = WR_REQ;
          end else if (rd_go) begin
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        sdram_wr_req = ~sdram_wr_ack;
        if (sdram_wr_ack) begin
          wr_pop  = 1'b1;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (sdram_wr_ack) begin
          wr_pop = 1'b1;
        end else begin
          state_d   = IDLE;
          used_d    = used_q + BURST_U;
          wr_addr_d = wrap_add(wr_addr_q, BURST_A,
                               BASE_ADDR, REGION_WORDS);
        end
      end
      RD_REQ: begin
        sdram_rd_req = ~sdram_rd_ack;
        if (sdram_rd_ack) begin
          rd_push = 1'b1;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (sdram_rd_ack) begin
          rd_push = 1'b1;
        end else begin
          state_d   = IDLE;
          used_d    = used_q - BURST_U;
          rd_addr_d = wrap_add(rd_addr_q, BURST_A,
                               BASE_ADDR, REGION_WORDS);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state, burst pointers, fill and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_addr_q <= BASE_ADDR;
      rd_addr_q <= BASE_ADDR;
      used_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      used_q    <= used_d;
      ovf_q     <= ovf_d;
    end
  end

  assign overflow       = ovf_q;
  assign region_used    = used_q;
  assign sdram_wr_addr  = wr_addr_q;
  assign sdram_rd_addr  = rd_addr_q;
  assign sdram_wr_burst = BURST_W'(BURST);
  assign sdram_rd_burst = BURST_W'(BURST);

endmodule

// File: tb/tb_sdram_burst_bridge.sv
// tb_sdram_burst_bridge: random user traffic against a stream
// model plus a behavioural SDRAM controller with its own memory.
module tb_sdram_burst_bridge;

  localparam int BL = 8;
  localparam int FD = 16;
  localparam int RW = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        wr_full;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        rd_empty;
  logic        overflow;
  logic [24:0] region_used;
  logic        sdram_init_done = 1'b0;
  logic        sdram_wr_req;
  logic        sdram_wr_ack = 1'b0;
  logic [23:0] sdram_wr_addr;
  logic [9:0]  sdram_wr_burst;
  logic [15:0] sdram_din;
  logic        sdram_rd_req;
  logic        sdram_rd_ack = 1'b0;
  logic [23:0] sdram_rd_addr;
  logic [9:0]  sdram_rd_burst;
  logic [15:0] sdram_dout = '0;

  sdram_burst_bridge #(
    .BURST        (BL),
    .FIFO_DEPTH   (FD),
    .BASE_ADDR    (24'h000000),
    .REGION_WORDS (24'(RW))
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .wr_full         (wr_full),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_empty        (rd_empty),
    .overflow        (overflow),
    .region_used     (region_used),
    .sdram_init_done (sdram_init_done),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_wr_addr   (sdram_wr_addr),
    .sdram_wr_burst  (sdram_wr_burst),
    .sdram_din       (sdram_din),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_rd_addr   (sdram_rd_addr),
    .sdram_rd_burst  (sdram_rd_burst),
    .sdram_dout      (sdram_dout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit rd;
    int req_c;
    int fall_c;
  } ev_t;

  logic [15:0] q[$];
  logic [15:0] smem [RW];
  ev_t         evs[$];
  int          total_wr = 0;
  int          wexp = 0;
  int          rexp = 0;
  int          mreg = 0;
  int          nreq = 0;
  int          cyc = 0;
  int          lat_max = 0;

  // Controller model: one burst at a time, BL acks each.
  initial begin : ctrl
    bit   wbusy, rbusy;
    int   wait_c, cnt, a;
    ev_t  e;
    wbusy = 0;
    rbusy = 0;
    wait_c = 0;
    cnt = 0;
    a = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        wbusy = 0;
        rbusy = 0;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
      end else begin
        if (!wbusy && !rbusy) begin
          if (sdram_wr_req) begin
            nreq++;
            chk("wr_addr", sdram_wr_addr, wexp);
            chk("wr_room", 32'(mreg <= RW - BL), 1);
            chk("used_at_wr", region_used, mreg);
            wbusy = 1;
            a = int'(sdram_wr_addr);
            cnt = 0;
            wait_c = $urandom_range(0, lat_max);
            e.rd = 0;
            e.req_c = cyc;
            e.fall_c = 0;
          end else if (sdram_rd_req) begin
            nreq++;
            chk("rd_addr", sdram_rd_addr, rexp);
            chk("rd_avail", 32'(mreg >= BL), 1);
            chk("used_at_rd", region_used, mreg);
            rbusy = 1;
            a = int'(sdram_rd_addr);
            cnt = 0;
            wait_c = $urandom_range(0, lat_max);
            e.rd = 1;
            e.req_c = cyc;
            e.fall_c = 0;
          end
        end
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        if (wbusy || rbusy) begin
          if (wait_c > 0) begin
            wait_c--;
          end else if (wbusy) begin
            sdram_wr_ack = 1'b1;
            smem[(a + cnt) % RW] = sdram_din;
            cnt++;
            if (cnt == BL) begin
              chk("wr_hold", {sdram_wr_burst, sdram_wr_addr},
                  {10'(BL), 24'(a)});
              wbusy = 0;
              mreg += BL;
              wexp = (wexp + BL) % RW;
              e.fall_c = cyc + 1;
              evs.push_back(e);
            end
          end else begin
            sdram_rd_ack = 1'b1;
            sdram_dout = smem[(a + cnt) % RW];
            cnt++;
            if (cnt == BL) begin
              chk("rd_hold", {sdram_rd_burst, sdram_rd_addr},
                  {10'(BL), 24'(a)});
              rbusy = 0;
              mreg -= BL;
              rexp = (rexp + BL) % RW;
              e.fall_c = cyc + 1;
              evs.push_back(e);
            end
          end
        end
      end
    end
  end

  // One user cycle: optional read (checked) and write.
  task automatic step(input bit w, input bit r,
                      input logic [15:0] d);
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    if (r && !rd_empty) begin
      rd_en = 1'b1;
      if (q.size() == 0) begin
        chk("rd_extra", 1, 0);
      end else begin
        chk("rd_data", rd_data, q.pop_front());
      end
    end
    if (w && !wr_full) begin
      wr_en = 1'b1;
      wr_data = d;
      q.push_back(d);
      total_wr++;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && q.size() > 0; i++) begin
      step(0, 1, 16'h0);
    end
    chk("drained", q.size(), 0);
    repeat (3) step(0, 0, 16'h0);
    chk("used_zero", region_used, 0);
    chk("rd_empty_end", rd_empty, 1);
    chk("wr_ptr_end", sdram_wr_addr, wexp);
    chk("rd_ptr_end", sdram_rd_addr, rexp);
  endtask

  task automatic rst_chk(input string t);
    chk({t, "_wreq"}, sdram_wr_req, 0);
    chk({t, "_rreq"}, sdram_rd_req, 0);
    chk({t, "_waddr"}, sdram_wr_addr, 0);
    chk({t, "_raddr"}, sdram_rd_addr, 0);
    chk({t, "_used"}, region_used, 0);
    chk({t, "_ovf"}, overflow, 0);
    chk({t, "_full"}, wr_full, 0);
    chk({t, "_empty"}, rd_empty, 1);
    chk({t, "_rdata"}, rd_data, 0);
    chk({t, "_din"}, sdram_din, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int wp[4] = '{90, 70, 50, 30};
    int rp[4] = '{0, 30, 60, 90};

    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_chk("por");
    reset_n = 1'b1;
    sdram_init_done = 1'b1;

    // Words 1..8: one write to 0, then read back from 0.
    lat_max = 0;
    for (int i = 1; i <= BL; i++) step(1, 0, 16'(i));
    for (int i = 0; i < 100 && evs.size() < 2; i++) begin
      step(0, 0, 16'h0);
    end
    chk("p1_nev", evs.size(), 2);
    if (evs.size() >= 2) begin
      chk("p1_ev0_wr", evs[0].rd, 0);
      chk("p1_ev1_rd", evs[1].rd, 1);
    end
    chk("p1_wr_next", sdram_wr_addr, 8);
    drain();

    // Random traffic with controller latency 0..3.
    lat_max = 3;
    for (int rr = 0; rr < 4; rr++) begin
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 99) < wp[rr],
             $urandom_range(0, 99) < rp[rr],
             16'($urandom));
      end
    end
    for (int i = 0; i < 400 && (total_wr % BL) != 0; i++) begin
      step(1, 1, 16'($urandom));
    end
    drain();
    chk("rand_ovf", overflow, 0);

    // Fill past full with init low, then release.
    lat_max = 0;
    evs.delete();
    nreq = 0;
    sdram_init_done = 1'b0;
    for (int i = 0; i <= FD; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_data = 16'(16'h0100 + i);
      if (i < FD) begin
        q.push_back(wr_data);
        total_wr++;
      end else begin
        chk("p3_full", wr_full, 1);
      end
    end
    step(0, 0, 16'h0);
    repeat (3) step(0, 0, 16'h0);
    chk("p3_ovf", overflow, 1);
    chk("p3_noreq", nreq, 0);
    chk("p3_full_hold", wr_full, 1);
    sdram_init_done = 1'b1;
    for (int i = 0; i < 200 && evs.size() < 3; i++) begin
      step(0, 0, 16'h0);
    end
    chk("p3_nev", 32'(evs.size() >= 3), 1);
    if (evs.size() >= 3) begin
      chk("p3_ev0_wr", evs[0].rd, 0);
      chk("p3_ev1_wr", evs[1].rd, 0);
      chk("p3_ev2_rd", evs[2].rd, 1);
      chk("p3_gap", evs[2].req_c - evs[1].fall_c, 2);
    end
    drain();

    // Reset in the middle of a write burst.
    for (int i = 0; i < BL; i++) step(1, 0, 16'($urandom));
    for (int i = 0; i < 50 && !sdram_wr_ack; i++) begin
      step(0, 0, 16'h0);
    end
    chk("p4_in_burst", sdram_wr_ack, 1);
    step(0, 0, 16'h0);
    #1 reset_n = 1'b0;
    #1 rst_chk("mid");
    repeat (2) @(negedge clk);
    q.delete();
    evs.delete();
    nreq = 0;
    wexp = 0;
    rexp = 0;
    mreg = 0;
    total_wr = 0;
    reset_n = 1'b1;
    repeat (20) step(0, 0, 16'h0);
    chk("p4_idle", nreq, 0);
    for (int i = 0; i < BL - 1; i++) step(1, 0, 16'($urandom));
    repeat (10) step(0, 0, 16'h0);
    chk("p4_seven", nreq, 0);
    step(1, 0, 16'($urandom));
    for (int i = 0; i < 100 && evs.size() < 2; i++) begin
      step(0, 0, 16'h0);
    end
    chk("p4_nev", evs.size(), 2);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_burst_bridge.md
# sdram_burst_bridge

Streaming front end for `sdram_controller`. Buffers a user write stream in an internal write FIFO and issues full-length burst writes to a circular SDRAM region. Refills an internal read FIFO with burst reads from the same region. Sits directly upstream of the controller and drives its `sdram_wr_*`/`sdram_rd_*` request/ack ports.

## Interface
- `BURST`, 256: words per SDRAM burst; range 1..512.
- `FIFO_DEPTH`, 1024: depth of each internal FIFO, in words; power of two, ≥ 2·BURST.
- `BASE_ADDR`, 24'h000000: first word address of the circular region.
- `REGION_WORDS`, 24'h010000: region size in words; multiple of BURST.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: user write strobe.
- `wr_data` in 16: user write word.
- `wr_full` out 1: write FIFO full.
- `rd_en` in 1: user read strobe.
- `rd_data` out 16: head of read FIFO (show-ahead).
- `rd_empty` out 1: read FIFO empty.
- `overflow` out 1: sticky; set by `wr_en` while `wr_full`.
- `region_used` out 25: words held in SDRAM, not yet read back.
- `sdram_init_done` in 1: controller init complete.
- `sdram_wr_req` out 1: write burst request.
- `sdram_wr_ack` in 1: high for each cycle the controller takes one `sdram_din` word.
- `sdram_wr_addr` out 24: write burst start address.
- `sdram_wr_burst` out 10: constant BURST.
- `sdram_din` out 16: write FIFO head.
- `sdram_rd_req` out 1: read burst request.
- `sdram_rd_ack` in 1: high for each cycle `sdram_dout` carries a valid word.
- `sdram_rd_addr` out 24: read burst start address.
- `sdram_rd_burst` out 10: constant BURST.
- `sdram_dout` in 16: read data from controller.

## Operation
- FSM states: IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA.
- In IDLE, a request is considered only when `sdram_init_done`=1.
- Write condition: write FIFO level ≥ BURST and `region_used` ≤ REGION_WORDS−BURST.
- Read condition: `region_used` ≥ BURST and read FIFO free space ≥ BURST.
- Arbitration: write has priority. If both conditions hold, the write is taken.
- IDLE→WR_REQ: `sdram_wr_req`=1 and held until `sdram_wr_ack` rises. Req drops in the cycle ack is first seen high.
- WR_REQ→WR_DATA on ack=1. In WR_DATA, the write FIFO pops once per ack-high cycle.
- WR_DATA→IDLE on ack fall. On that edge, `sdram_wr_addr` += BURST and `region_used` += BURST.
- The RD path is symmetric. The read FIFO pushes `sdram_dout` on each `sdram_rd_ack`-high cycle. Completion adds BURST to `sdram_rd_addr` and subtracts BURST from `region_used`.
- Address wrap: when the next address would equal BASE_ADDR+REGION_WORDS, it loads BASE_ADDR instead.
- Pointers advance by exactly BURST per completed burst, regardless of the ack-cycle count. The controller contract guarantees BURST acks per burst.
- User `wr_en` while full: word dropped, `overflow` set. `rd_en` while empty: ignored.
- Simultaneous user push and pop are legal on both FIFOs in the same cycle.

## Timing
- Reset values:
  - req outputs 0.
  - `sdram_wr_addr` = `sdram_rd_addr` = BASE_ADDR.
  - `region_used` 0, `overflow` 0.
  - `wr_full` 0, `rd_empty` 1.
  - `rd_data`/`sdram_din` 0.
  - FSM IDLE, FIFOs empty.
- Reset mid-burst: reset immediately returns the block to the reset state above. Data in the partial burst is lost.
- FIFO flag latency:
  - `wr_full`/`rd_empty` are registered.
  - Push to `rd_empty`=0 takes 1 cycle.
  - `sdram_din` updates the cycle after each pop, ready for the next ack cycle.
- Request issue: at earliest 1 cycle after its condition becomes true in IDLE.
- Turnaround: 1 idle cycle minimum between ack fall and the next req.
- Burst length and address outputs are stable from req assertion through ack fall.

## Structure
- Shared package `sdram_pkg`:
  - FSM state enum.
  - Widths: data 16, address 24, burst 10.
- One sub-module `sync_fifo`: parameterised width/depth, show-ahead, registered full/empty, level output. Instantiated twice.

## Test plan
- BURST=8, controller model acks 8 cycles. Write 8 words 0x0001..0x0008 → one write req at address 0; `region_used`=8; next write address 8.
- Continue with the same 8 words → read req at address 0. `rd_data` returns 0x0001..0x0008 in order; `region_used`=0.
- REGION_WORDS=16. Write 24 words with no user reads → third write burst withheld until a read completes. Then it goes to address 0 (wrap); `region_used` never exceeds 16.
- Hold the write FIFO at ≥ BURST and the read condition true together → write req issued first; read req follows after write ack fall plus 1 cycle.
- Push FIFO_DEPTH+1 words with `sdram_init_done`=0 → no reqs; `wr_full`=1; `overflow`=1. Raise init_done → bursts start.
- Assert `reset_n`=0 during WR_DATA → all outputs return to reset values in the same cycle; no req after release until 8 new words arrive.
